// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned W  = 32;
  localparam int unsigned L  = 64;
  localparam int unsigned AW = $clog2(L * (W / 8));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] WM_READ = 2'd0;
  localparam logic [1:0] WM_BYTE = 2'd1;
  localparam logic [1:0] WM_HALF = 2'd2;
  localparam logic [1:0] WM_WORD = 2'd3;

  localparam logic P_FETCH = 1'b0;
  localparam logic P_DATA  = 1'b1;

  // Latched transaction presented to the RAM
  typedef struct packed {
    logic          port;
    logic [1:0]    wmode;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
  } req_t;

  // Half accesses need an even address, word accesses a 4-byte aligned one
  function automatic logic misaligned(input logic [1:0] wmode, input logic [1:0] addr_lo);
    return ((wmode == WM_HALF) && addr_lo[0]) ||
           (((wmode == WM_READ) || (wmode == WM_WORD)) && (addr_lo != 2'd0));
  endfunction

endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: 2-way round-robin picker; the port not granted last wins a tie.
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       update,
  output logic       gnt,
  output logic       valid
);

  // Single requester always wins; on a tie the other port from last grant wins
  always_comb begin
    gnt   = req[1] & (~req[0] | (last == P_FETCH));
    valid = update & (|req);
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port byte RAM between fetch (p0) and data (p1).
// Optional misalignment checking is enabled by defining RAM_ARB_ALIGN_CHECK_EN.
module ram_arbiter
  import ram_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  output logic          p0_ack,
  output logic [W-1:0]  p0_rdata,
  input  logic          p1_req,
  input  logic [1:0]    p1_wmode,
  input  logic [AW-1:0] p1_addr,
  input  logic [W-1:0]  p1_wdata,
  output logic          p1_ack,
  output logic [W-1:0]  p1_rdata,
`ifdef RAM_ARB_ALIGN_CHECK_EN
  output logic          p0_err,
  output logic          p1_err,
`endif
  output logic [AW-1:0] ram_addr,
  output logic [W-1:0]  ram_data_in,
  output logic          ram_oe,
  output logic [1:0]    ram_w_mode,
  input  logic [W-1:0]  ram_data_out
);

  state_t     state;
  logic       last_gnt;
  logic       rr_gnt;
  logic       rr_valid;
  req_t       cur;
  req_t       nxt;
  logic       bad_nxt;
  logic       bad_q;
  logic       oe_q;
  logic [1:0] wm_q;

  ram_arb_rr u_rr (
    .req    ({p1_req, p0_req}),
    .last   (last_gnt),
    .update (state == IDLE),
    .gnt    (rr_gnt),
    .valid  (rr_valid)
  );

  // Build the candidate transaction from the winning port; fetches are word reads
  always_comb begin
    nxt      = '0;
    nxt.port = rr_gnt;
    if (rr_gnt == P_FETCH) begin
      nxt.wmode = WM_READ;
      nxt.addr  = p0_addr;
    end else begin
      nxt.wmode = p1_wmode;
      nxt.addr  = p1_addr;
      nxt.wdata = p1_wdata;
    end
  end

`ifdef RAM_ARB_ALIGN_CHECK_EN
  assign bad_nxt = misaligned(nxt.wmode, nxt.addr[1:0]);
`else
  assign bad_nxt = 1'b0;
`endif

  // RAM strobes are killed immediately by reset so an in-flight write never commits
  assign ram_addr    = cur.addr;
  assign ram_data_in = cur.wdata;
  assign ram_oe      = oe_q & ~rst;
  assign ram_w_mode  = rst ? WM_READ : wm_q;

  // Arbitration FSM, request latch and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= P_DATA;
      cur      <= '0;
      bad_q    <= 1'b0;
      oe_q     <= 1'b0;
      wm_q     <= WM_READ;
      p0_ack   <= 1'b0;
      p1_ack   <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
`ifdef RAM_ARB_ALIGN_CHECK_EN
      p0_err   <= 1'b0;
      p1_err   <= 1'b0;
`endif
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
`ifdef RAM_ARB_ALIGN_CHECK_EN
      p0_err <= 1'b0;
      p1_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rr_valid) begin
            cur      <= nxt;
            last_gnt <= rr_gnt;
            bad_q    <= bad_nxt;
            if (!bad_nxt) begin
              wm_q <= nxt.wmode;
              oe_q <= (nxt.wmode == WM_READ);
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          oe_q <= 1'b0;
          wm_q <= WM_READ;
          if ((cur.wmode == WM_READ) && !bad_q) begin
            if (cur.port == P_FETCH) p0_rdata <= ram_data_out;
            else                     p1_rdata <= ram_data_out;
          end
          if (cur.port == P_FETCH) p0_ack <= 1'b1;
          else                     p1_ack <= 1'b1;
`ifdef RAM_ARB_ALIGN_CHECK_EN
          if (cur.port == P_FETCH) p0_err <= bad_q;
          else                     p1_err <= bad_q;
`endif
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester controller that sequences and shares the single-port byte-addressable RAM (W=32, L=64, 8-bit byte address) between an instruction-fetch port (word reads only) and a data port (reads plus byte/half/word writes). It sits between the core's fetch and load/store units and the RAM. It arbitrates round-robin, latches the winning request, and drives the RAM's addr/data_in/oe/w_mode for exactly one cycle. It then returns read data and an ack pulse.

## Interface
- W, 32, data width in bits
- L, 64, RAM depth in words
- AW, $clog2(L*(W/8)), byte-address width (8 for defaults)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- p0_req  in  1  fetch request, held until p0_ack
- p0_addr  in  AW  fetch byte address, stable while p0_req
- p0_ack  out  1  one-cycle completion pulse
- p0_rdata  out  W  fetched word, valid when p0_ack
- p1_req  in  1  data request, held until p1_ack
- p1_wmode  in  2  0 read word, 1 write byte, 2 write half, 3 write word
- p1_addr  in  AW  data byte address
- p1_wdata  in  W  write data, low bytes used for byte/half
- p1_ack  out  1  one-cycle completion pulse
- p1_rdata  out  W  read word, valid when p1_ack and p1_wmode was 0
- p0_err, p1_err  out  1  misalignment error, valid with ack (only with RAM_ARB_ALIGN_CHECK_EN)
- ram_addr  out  AW  to RAM addr
- ram_data_in  out  W  to RAM data_in
- ram_oe  out  1  to RAM oe
- ram_w_mode  out  2  to RAM w_mode
- ram_data_out  in  W  from RAM data_out (combinational read)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, pick a winner and latch its port id, addr, wmode and wdata. Go to ACCESS. Otherwise stay in IDLE.
- Fetch requests are latched as wmode 0.
- Round-robin: one last-grant bit. On simultaneous requests, the port not granted last wins. With a single request, that port wins regardless of the bit. The bit updates on every grant.
- ACCESS: drive ram_addr and ram_data_in from the latched values. ram_w_mode = latched wmode.
  - ram_oe = 1 only for reads.
  - For reads, capture ram_data_out into the winner's rdata register at the clock edge.
  - For writes, the RAM commits at that same edge.
  - Go to RESP.
- RESP: assert the winner's ack for one cycle, then return to IDLE.
- rdata registers hold their value until the next read on the same port. The loser's ack stays 0.
- Outside ACCESS, ram_oe=0 and ram_w_mode=0; ram_addr and ram_data_in hold the last latched values.
- Requesters deassert req in the ack cycle or later. A req still high in IDLE after its ack is a new transaction.
- Requests arriving during ACCESS or RESP wait. They are sampled only in IDLE.

## Timing
- Latency: req high in IDLE at cycle n; RAM access in cycle n+1; ack in cycle n+2; next grant possible at n+3.
- Throughput: one transaction per 3 cycles. Under continuous contention, grants alternate p0, p1, p0, …
- Reset values: state IDLE, last-grant=1 (p0 wins first tie), p0_ack=p1_ack=0, p0_rdata=p1_rdata=0, errs=0, ram_addr=0, ram_data_in=0, ram_oe=0, ram_w_mode=0.
- Reset mid-operation: ram_w_mode and ram_oe are forced to 0 combinationally while rst=1. A write in ACCESS is therefore suppressed. No ack is issued for an aborted transaction.

## Configuration
- RAM_ARB_ALIGN_CHECK_EN defined:
  - In ACCESS, a latched request is misaligned if it is a half write with addr[0]=1, or a word read/write with addr[1:0]!=0.
  - A misaligned request keeps ram_w_mode=0 and ram_oe=0, so the RAM is untouched.
  - RESP then asserts ack with err=1; rdata is not updated.
  - Aligned requests return err=0.
- Undefined: p0_err and p1_err ports do not exist. Every address passes through to the RAM unchecked; misaligned behaviour is the RAM's.

## Structure
- Package ram_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP)
  - w_mode constants WM_READ=0, WM_BYTE=1, WM_HALF=2, WM_WORD=3
  - port-id constants P_FETCH=0, P_DATA=1
- Sub-module ram_arb_rr: 2-way round-robin picker with inputs req[1:0], last and update, and outputs gnt and valid.
- The FSM, request latches and response registers live in ram_arbiter.

## Test plan
- Fetch only: preload word 0x11223344 at addr 0x10, p0_req with p0_addr=0x10 → p0_ack 2 cycles later, p0_rdata=0x11223344, p1_ack=0.
- Byte write then read: p1 wmode=1, addr=0x21, wdata=0xAB. Then a p1 read at addr 0x20 with prior word 0 → p1_rdata=0x0000AB00.
- Contention: p0 and p1 held high together from reset → ack order p0, p1, p0, p1, with acks 3 cycles apart.
- Half write: p1 wmode=2, addr=0x30, wdata=0xDEADBEEF → a word read at 0x30 returns 0x0000BEEF (bytes 0x32–0x33 unchanged at 0).
- Reset during ACCESS of a word write to 0x40 → no ack; word at 0x40 unchanged; all outputs at reset values the next cycle.
- With RAM_ARB_ALIGN_CHECK_EN: p1 word write at 0x42 → p1_ack with p1_err=1, ram_w_mode stays 0, memory unchanged. Aligned 0x44 → p1_err=0.
